// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS core: next-PC selection, stall/halt, retire count.
// Optional misaligned jump-register trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        halt_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jump_reg_i,
    input  logic [31:0] reg_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_valid_o,
    output logic        halted_o,
    output logic [31:0] instr_count_o
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic        trap_o,
    output logic [31:0] epc_o
`endif
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg_i) begin
            next_pc = reg_target_i;
        end else if (jump_i) begin
            next_pc = {pc_plus4[31:28], jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
            next_pc = branch_target;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] epc_q, epc_d;
`else
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d  = 1'b0;
        epc_d   = epc_q;
`endif
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (!stall_i) begin
                    count_d = count_q + 32'd1;
                    if (halt_i) begin
                        // The halt instruction retires but the PC stays on it.
                        state_d = StHalt;
                    end else begin
`ifdef PC_MISALIGN_TRAP_EN
                        if (next_pc[1:0] != 2'b00) begin
                            pc_d   = TRAP_VEC;
                            epc_d  = reg_target_i;
                            trap_d = 1'b1;
                        end else begin
                            pc_d = next_pc;
                        end
`else
                        pc_d = next_pc;
`endif
                    end
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StBoot;
            pc_q    <= RESET_VEC;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trap_q <= 1'b0;
            epc_q  <= 32'd0;
        end else begin
            trap_q <= trap_d;
            epc_q  <= epc_d;
        end
    end

    assign trap_o = trap_q;
    assign epc_o  = epc_q;
`endif

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign fetch_valid_o = (state_q == StRun);
    assign halted_o      = (state_q == StHalt);
    assign instr_count_o = count_q;

endmodule
